// File: rtl/gpio_cmd_regfile_pkg.sv
// Shared opcodes, GPIO field positions and FSM states for the GPIO command register file.
package gpio_cmd_regfile_pkg;

   localparam int STRB_BIT = 23;
   localparam int OP_HI    = 31;
   localparam int OP_LO    = 24;

   localparam logic [7:0] OP_SOFT_RST  = 8'h01;
   localparam logic [7:0] OP_EN_TX     = 8'h02;
   localparam logic [7:0] OP_EN_RX     = 8'h03;
   localparam logic [7:0] OP_PHASE     = 8'h04;
   localparam logic [7:0] OP_RUN_LOG   = 8'h05;
   localparam logic [7:0] OP_READ_LOG  = 8'h06;
   localparam logic [7:0] OP_BER_LATCH = 8'h07;
   localparam logic [7:0] OP_BER_READ  = 8'h08;
   localparam logic [7:0] OP_STATUS    = 8'h09;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM_WAIT} state_t;

endpackage

// File: rtl/gpio_cmd_regfile_ber_snapshot_mux.sv
// Coherent snapshot of all BER counters plus 32-bit word selection for readback.
module ber_snapshot_mux #(
   parameter int NB_GPIO = 32,
   parameter int NB_CH   = 2,
   parameter int NB_CNT  = 64,
   parameter int CH_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    latch,
   input  logic [NB_CH*NB_CNT-1:0] samp,
   input  logic [NB_CH*NB_CNT-1:0] err,
   input  logic [CH_W+1:0]         sel,
   output logic [NB_GPIO-1:0]      word
);
   localparam int NB_W = 2*NB_GPIO;

   logic [NB_CH-1:0][NB_W-1:0] samp_q, err_q;
   logic [CH_W-1:0]            ch;
   logic [NB_W-1:0]            cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_q <= '0;
         err_q  <= '0;
      end else if (latch) begin
         for (int c = 0; c < NB_CH; c++) begin
            samp_q[c] <= NB_W'(samp[c*NB_CNT +: NB_CNT]);
            err_q[c]  <= NB_W'(err[c*NB_CNT +: NB_CNT]);
         end
      end
   end

   // channel field is one bit wider than needed so out-of-range indices read as zero
   assign ch = sel[CH_W+1:2];

   always_comb begin
      cnt = '0;
      for (int c = 0; c < NB_CH; c++)
         if (ch == CH_W'(c)) cnt = sel[1] ? err_q[c] : samp_q[c];
      word = sel[0] ? cnt[NB_W-1:NB_GPIO] : cnt[NB_GPIO-1:0];
   end

endmodule

// File: rtl/gpio_cmd_regfile.sv
// GPIO command register file: strobed GPO commands drive DSP/log-memory controls and GPI readback.
// Optional macro GPIO_CMD_REGFILE_CMDCNT_EN adds an executed-command counter and STATUS opcode 0x09.
module gpio_cmd_regfile
   import gpio_cmd_regfile_pkg::*;
#(
   parameter int NB_GPIO  = 32,
   parameter int NB_CH    = 2,
   parameter int NB_CNT   = 64,
   parameter int NB_ADDR  = 15,
   parameter int NB_PHASE = 2,
   parameter int RST_CYC  = 16
) (
   input  logic                    clk,
   input  logic                    i_rstn,
   input  logic [NB_GPIO-1:0]      i_gpio,
   input  logic                    i_mem_full,
   input  logic [NB_GPIO-1:0]      i_data_log_from_mem,
   input  logic [NB_CH*NB_CNT-1:0] i_ber_samp,
   input  logic [NB_CH*NB_CNT-1:0] i_ber_error,
   output logic [NB_GPIO-1:0]      o_gpio,
   output logic                    o_soft_rst,
   output logic                    o_enb_tx,
   output logic                    o_enb_rx,
   output logic [NB_PHASE-1:0]     o_phase_sel,
   output logic                    o_run_log,
   output logic                    o_read_log,
   output logic [NB_ADDR-1:0]      o_addr_log_to_mem
);
   localparam int CH_W = $clog2(NB_CH) + 1;
   localparam int RC_W = $clog2(RST_CYC + 1);

   state_t                 state, state_nxt;
   logic                   strb_q, full_q, strb_edge, mem_rise, exec;
   logic [OP_HI-OP_LO:0]   op_q;
   logic [STRB_BIT-1:0]    data_q;
   logic [RC_W-1:0]        rst_cnt;
   logic [NB_GPIO-1:0]     ber_word;
   logic                   unused_data;

   assign strb_edge   = i_gpio[STRB_BIT] & ~strb_q;
   assign mem_rise    = i_mem_full & ~full_q;
   assign exec        = (state == S_EXEC);
   assign o_soft_rst  = (rst_cnt != '0);
   assign unused_data = ^data_q;

   always_ff @(posedge clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state  <= S_IDLE;
         strb_q <= 1'b0;
         full_q <= 1'b0;
         op_q   <= '0;
         data_q <= '0;
      end else begin
         state  <= state_nxt;
         strb_q <= i_gpio[STRB_BIT];
         full_q <= i_mem_full;
         if (state == S_IDLE && strb_edge) begin
            op_q   <= i_gpio[OP_HI:OP_LO];
            data_q <= i_gpio[STRB_BIT-1:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (strb_edge) state_nxt = S_EXEC;
         S_EXEC:     state_nxt = (op_q == OP_READ_LOG) ? S_MEM_WAIT : S_IDLE;
         S_MEM_WAIT: state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

`ifdef GPIO_CMD_REGFILE_CMDCNT_EN
   logic [7:0]         cmd_cnt;
   logic [NB_GPIO-1:0] status;
   assign status = {cmd_cnt, {(NB_GPIO-13-NB_PHASE){1'b0}}, o_run_log, o_read_log,
                    i_mem_full, o_phase_sel, o_enb_rx, o_enb_tx};

   always_ff @(posedge clk or negedge i_rstn) begin
      if (!i_rstn)   cmd_cnt <= '0;
      else if (exec) cmd_cnt <= cmd_cnt + 8'd1;
   end
`endif

   // command execution wins over a same-cycle i_mem_full rise because it is assigned later
   always_ff @(posedge clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_gpio            <= '0;
         o_enb_tx          <= 1'b0;
         o_enb_rx          <= 1'b0;
         o_phase_sel       <= '0;
         o_run_log         <= 1'b0;
         o_read_log        <= 1'b0;
         o_addr_log_to_mem <= '0;
         rst_cnt           <= '0;
      end else begin
         if (rst_cnt != '0)        rst_cnt   <= rst_cnt - RC_W'(1);
         if (mem_rise)             o_run_log <= 1'b0;
         if (state == S_MEM_WAIT)  o_gpio    <= i_data_log_from_mem;
         if (exec) begin
            case (op_q)
               OP_SOFT_RST: begin
                  rst_cnt    <= RC_W'(RST_CYC);
                  o_enb_tx   <= 1'b0;
                  o_enb_rx   <= 1'b0;
                  o_run_log  <= 1'b0;
                  o_read_log <= 1'b0;
               end
               OP_EN_TX: o_enb_tx    <= data_q[0];
               OP_EN_RX: o_enb_rx    <= data_q[0];
               OP_PHASE: o_phase_sel <= data_q[NB_PHASE-1:0];
               OP_RUN_LOG: begin
                  o_run_log  <= 1'b1;
                  o_read_log <= 1'b0;
               end
               OP_READ_LOG: begin
                  o_read_log        <= 1'b1;
                  o_run_log         <= 1'b0;
                  o_addr_log_to_mem <= data_q[NB_ADDR-1:0];
               end
               OP_BER_LATCH: o_gpio <= '0;
               OP_BER_READ:  o_gpio <= ber_word;
`ifdef GPIO_CMD_REGFILE_CMDCNT_EN
               OP_STATUS:    o_gpio <= status;
`endif
               default:      o_gpio <= '1;
            endcase
         end
      end
   end

   ber_snapshot_mux #(
      .NB_GPIO(NB_GPIO), .NB_CH(NB_CH), .NB_CNT(NB_CNT), .CH_W(CH_W)
   ) u_snap (
      .clk   (clk),
      .rst_n (i_rstn),
      .latch (exec && op_q == OP_BER_LATCH),
      .samp  (i_ber_samp),
      .err   (i_ber_error),
      .sel   (data_q[CH_W+1:0]),
      .word  (ber_word)
   );

endmodule

// File: tb/tb_gpio_cmd_regfile.sv
// Directed-vector bench for gpio_cmd_regfile with hand-computed expectations.
module tb_gpio_cmd_regfile;

   logic          clk = 1'b0;
   logic          i_rstn;
   logic [31:0]   i_gpio;
   logic          i_mem_full;
   logic [31:0]   i_data_log_from_mem;
   logic [127:0]  i_ber_samp, i_ber_error;
   logic [31:0]   o_gpio;
   logic          o_soft_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log;
   logic [1:0]    o_phase_sel;
   logic [14:0]   o_addr_log_to_mem;

   int n_vec = 0;
   int n_err = 0;
   int ncmd  = 0;

   always #5 clk = ~clk;

   gpio_cmd_regfile dut (
      .clk                 (clk),
      .i_rstn              (i_rstn),
      .i_gpio              (i_gpio),
      .i_mem_full          (i_mem_full),
      .i_data_log_from_mem (i_data_log_from_mem),
      .i_ber_samp          (i_ber_samp),
      .i_ber_error         (i_ber_error),
      .o_gpio              (o_gpio),
      .o_soft_rst          (o_soft_rst),
      .o_enb_tx            (o_enb_tx),
      .o_enb_rx            (o_enb_rx),
      .o_phase_sel         (o_phase_sel),
      .o_run_log           (o_run_log),
      .o_read_log          (o_read_log),
      .o_addr_log_to_mem   (o_addr_log_to_mem)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // raise the strobe; returns 1ns after edge cycle N
   task automatic strobe(input logic [7:0] op, input logic [22:0] d);
      @(negedge clk);
      i_gpio = {op, 1'b1, d};
      @(posedge clk); #1;
      ncmd++;
   endtask

   // drop the strobe; returns 1ns after the next rising edge
   task automatic step();
      @(negedge clk);
      i_gpio[23] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic cmd(input logic [7:0] op, input logic [22:0] d);
      strobe(op, d);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         hi_cnt;
      int         n_before;
      logic [31:0] exp_st;

      i_rstn = 1'b0;
      i_gpio = '0;
      i_mem_full = 1'b0;
      i_data_log_from_mem = 32'h0;
      i_ber_samp = '0;
      i_ber_error = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gpio", o_gpio, 0);
      chk("rst_soft", o_soft_rst, 0);
      chk("rst_tx", o_enb_tx, 0);
      chk("rst_rx", o_enb_rx, 0);
      chk("rst_phase", o_phase_sel, 0);
      chk("rst_run", o_run_log, 0);
      chk("rst_read", o_read_log, 0);
      chk("rst_addr", o_addr_log_to_mem, 0);
      @(negedge clk) i_rstn = 1'b1;

      // reset while in MEM_WAIT
      i_data_log_from_mem = 32'h1357_9BDF;
      cmd(8'h06, 23'h0042);
      chk("mid_read", o_read_log, 1);
      i_rstn = 1'b0;
      #1;
      chk("mid_rst_read", o_read_log, 0);
      chk("mid_rst_addr", o_addr_log_to_mem, 0);
      chk("mid_rst_gpio", o_gpio, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) i_rstn = 1'b1;
      ncmd = 0;

      // enables and phase, with N vs N+1 timing
      strobe(8'h02, 23'd1);
      chk("tx_at_N", o_enb_tx, 0);
      step();
      chk("tx_at_N1", o_enb_tx, 1);
      cmd(8'h04, 23'd2);
      chk("phase", o_phase_sel, 2'b10);

      // RUN_LOG with full already high, then a genuine full rise
      i_mem_full = 1'b1;
      repeat (2) @(posedge clk);
      cmd(8'h05, 23'd0);
      chk("run_set", o_run_log, 1);
      repeat (3) @(posedge clk);
      #1 chk("run_level_hold", o_run_log, 1);
      @(negedge clk) i_mem_full = 1'b0;
      @(negedge clk) i_mem_full = 1'b1;
      @(posedge clk); #1;
      chk("run_full_rise", o_run_log, 0);

      // full rise coinciding with RUN_LOG execution
      @(negedge clk) i_mem_full = 1'b0;
      strobe(8'h05, 23'd0);
      @(negedge clk);
      i_gpio[23] = 1'b0;
      i_mem_full = 1'b1;
      @(posedge clk); #1;
      chk("run_vs_full", o_run_log, 1);

      // READ_LOG, plus an edge during MEM_WAIT that must be dropped
      cmd(8'h02, 23'd0);
      chk("tx_off", o_enb_tx, 0);
      i_data_log_from_mem = 32'hCAFE_F00D;
      strobe(8'h06, 23'h1234);
      step();
      chk("rd_addr", o_addr_log_to_mem, 15'h1234);
      chk("rd_flag", o_read_log, 1);
      chk("rd_clr_run", o_run_log, 0);
      @(negedge clk) i_gpio = {8'h02, 1'b1, 23'd1};
      @(posedge clk); #1;
      chk("rd_data", o_gpio, 32'hCAFE_F00D);
      step();
      chk("drop_edge", o_enb_tx, 0);

      // BER snapshot
      i_ber_samp  = {64'h0000_0000_0000_0009, 64'h1111_2222_3333_4444};
      i_ber_error = {64'h0000_0001_0000_0005, 64'h0000_0000_0000_0000};
      cmd(8'h07, 23'd0);
      chk("latch_gpio", o_gpio, 0);
      i_ber_samp  = {2{64'hDEAD_BEEF_DEAD_BEEF}};
      i_ber_error = {2{64'hA5A5_A5A5_A5A5_A5A5}};
      cmd(8'h08, 23'b1_1_1);
      chk("ber_ch1_err_hi", o_gpio, 32'h0000_0001);
      cmd(8'h08, 23'b1_1_0);
      chk("ber_ch1_err_lo", o_gpio, 32'h0000_0005);
      cmd(8'h08, 23'b0_0_1);
      chk("ber_ch0_samp_hi", o_gpio, 32'h1111_2222);
      cmd(8'h08, 23'b0_0_0);
      chk("ber_ch0_samp_lo", o_gpio, 32'h3333_4444);
      cmd(8'h08, 23'b11_1_0);
      chk("ber_ch3_oor", o_gpio, 32'h0);

      // SOFT_RST with strobe held high: exactly one pulse of 16 cycles
      cmd(8'h02, 23'd1);
      cmd(8'h03, 23'd1);
      strobe(8'h01, 23'd0);
      hi_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (o_soft_rst) hi_cnt++;
      end
      chk("soft_len", hi_cnt, 16);
      chk("soft_tx", o_enb_tx, 0);
      chk("soft_rx", o_enb_rx, 0);
      chk("soft_phase_kept", o_phase_sel, 2'b10);
      step();

      cmd(8'h7F, 23'd0);
      chk("unknown_op", o_gpio, 32'hFFFF_FFFF);

      n_before = ncmd;
      cmd(8'h09, 23'd0);
`ifdef GPIO_CMD_REGFILE_CMDCNT_EN
      exp_st = '0;
      exp_st[31:24] = 8'(n_before);
      exp_st[4]     = 1'b1;
      exp_st[3:2]   = 2'b10;
      chk("status", o_gpio, exp_st);
`else
      exp_st = 32'hFFFF_FFFF;
      chk("status_unknown", o_gpio, exp_st + 32'(n_before * 0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
